tmds_channel_decoder: RTL and testbench
=======================================

Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI TMDS channel encoder. Takes one 10-bit TMDS word per pixel clock from an external 1:10 deserializer whose word boundary is arbitrary.
- Finds the correct bit alignment (0..9) by hunting for control tokens, then decodes each symbol to 8-bit video data or 2-bit control data with DE.
- One instance per colour channel; the blue instance's cd output supplies {vsync,hsync}.

Parameters:
- LOCK_RUN, 16: consecutive control tokens at the current phase required to declare lock.
- SEARCH_WINDOW, 1024: cycles per phase attempt in SEARCH; also the token-starvation timeout in LOCKED. Must exceed one 800-clock line.
- CNT_W, 11: width of the window/timeout counter; must hold SEARCH_WINDOW.

Ports:
- clk_pixel  in  1: pixel clock (25 MHz); single clock domain.
- reset_n  in  1: asynchronous, active-low reset.
- raw_word  in  10: deserialized word, bit 0 = first bit received; one word every cycle.
- vd  out  8: decoded video data.
- cd  out  2: decoded control data.
- vde  out  1: 1 = vd valid; 0 = cd valid (or not locked).
- locked  out  1: alignment locked.
- phase  out  4: current bit offset, 0..9.
- sym_err  out  1: one-cycle pulse on loss of lock.

Behaviour:
- Reset (async, reset_n=0): vd=0, cd=0, vde=0, locked=0, phase=0, sym_err=0, prev_word=0, counters=0, state=SEARCH.
- Window:
  - prev_word <= raw_word every cycle.
  - cat = {raw_word, prev_word} (20 bits).
  - cand = cat[phase+9:phase], so phase 0 selects prev_word.
- Token classify (cand):
  - 10'b1101010100 -> cd=00
  - 10'b0010101011 -> cd=01
  - 10'b0101010100 -> cd=10
  - 10'b1010101011 -> cd=11
  - any other value is data.
- Data decode:
  - q = cand[9] ? ~cand[7:0] : cand[7:0].
  - d[0] = q[0].
  - For i=1..7: d[i] = q[i]^q[i-1] when cand[8]=1, else ~(q[i]^q[i-1]).
- Outputs are registered. Latency from raw_word to outputs is 2 cycles at phase 0, 1 cycle for phases 1..9 (the newer bits come from the current raw_word).
  - While locked: a token gives vde=0, cd=token value, vd holds its last value; data gives vde=1, vd=d, cd holds its last value.
  - While not locked: vde=0, vd=0, cd=0.
- State machine, states SEARCH and LOCKED:
  - SEARCH:
    - win_cnt increments every cycle.
    - run_cnt increments on a token and clears on data.
    - When run_cnt reaches LOCK_RUN: go to LOCKED, locked=1, clear counters. Lock wins if this coincides with window expiry.
    - When win_cnt reaches SEARCH_WINDOW-1 without lock: phase <= (phase==9) ? 0 : phase+1, and clear win_cnt and run_cnt.
  - LOCKED:
    - starve_cnt (shares the win_cnt register) clears on any token and increments on data.
    - When it reaches SEARCH_WINDOW-1: go to SEARCH, locked=0, sym_err=1 for one cycle, phase advances (9 wraps to 0), counters clear.
    - A token on the same cycle as the timeout wins: the counter clears and the block stays LOCKED.
- Phase wrap: phase 9 -> 0 in both states.
- Reset mid-operation: immediate return to the reset values, independent of the clock.
- Output drop: from the cycle locked falls, outputs are forced to the not-locked values.

Decomposition:
- Package tmds_pkg:
  - the four control-token localparams (CTRL_00..CTRL_11)
  - state encoding (SEARCH, LOCKED)
  - TMDS_W=10
- Sub-module tmds_symbol_decode: purely combinational, 10-bit cand in; outputs is_ctrl, cd[1:0], d[7:0].
- tmds_channel_decoder holds the window register, phase mux, FSM, counters and output registers.

Test Plan (bench uses SEARCH_WINDOW=64, LOCK_RUN=16, aligned stream unless stated):
- Reset, then 20 words of 10'h354 (CTRL_00) at phase 0 -> locked=1 on the cycle after the 16th token reaches cand; vde=0, cd=00, phase=0.
- Locked, then words 10'h100, 10'h200 -> vde=1 with vd=8'h00 then 8'hFF, in order, 2 cycles after each input; then 10'h0AB -> vde=0, cd=01.
- Bit stream of (16 x 10'h354, 40 x 10'h100) repeating, delayed by 3 bits across word boundaries -> phase steps 0,1,2,3 at 64-cycle intervals; locked=1 with phase=3 within 3*64+LOCK_RUN+2 cycles; decoded vd=00 afterwards.
- Locked, then 64 consecutive data words with no token -> sym_err one-cycle pulse, locked=0, vde=0, phase=1.
- Phase 9 in SEARCH with no tokens for 64 cycles -> phase wraps to 0, no sym_err.
- reset_n low for 1 ns mid-stream while locked with phase=3 -> outputs, phase and locked return to 0 immediately; relock requires a fresh run of 16 tokens.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS receive path: symbol width, control tokens, FSM states.
package tmds_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: control-token detect plus 8b data recovery.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [TMDS_W-1:0] cand,
    output logic              is_ctrl,
    output logic [1:0]        cd,
    output logic [7:0]        d
);

    logic [7:0] q;

    assign q = cand[9] ? ~cand[7:0] : cand[7:0];

    always_comb begin
        is_ctrl = 1'b1;
        cd      = 2'b00;
        case (cand)
            CTRL_00: cd = 2'b00;
            CTRL_01: cd = 2'b01;
            CTRL_10: cd = 2'b10;
            CTRL_11: cd = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    // cand[8] tells whether the transmitter used the XOR or XNOR chain
    always_comb begin
        d    = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = cand[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: hunts word alignment via control tokens, then decodes
// each aligned symbol into video data or control data.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN      = 16,
    parameter int SEARCH_WINDOW = 1024,
    parameter int CNT_W         = 11
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic [TMDS_W-1:0] raw_word,
    output logic [7:0]        vd,
    output logic [1:0]        cd,
    output logic              vde,
    output logic              locked,
    output logic [3:0]        phase,
    output logic              sym_err
);

    localparam int RUN_W = $clog2(LOCK_RUN + 1);

    logic [TMDS_W-1:0]   prev_word;
    logic [2*TMDS_W-1:0] cat;
    logic [TMDS_W-1:0]   cand;
    logic [0:0]          state;
    logic [CNT_W-1:0]    win_cnt;
    logic [RUN_W-1:0]    run_cnt;

    logic       is_ctrl;
    logic [1:0] tok_cd;
    logic [7:0] data;

    logic [3:0] phase_inc;
    logic       win_end;
    logic       lock_hit;
    logic       locked_nxt;

    // Phase 0 selects prev_word entirely; higher phases pull newer bits from raw_word
    assign cat  = {raw_word, prev_word};
    assign cand = cat[{1'b0, phase} +: TMDS_W];

    tmds_symbol_decode u_dec (
        .cand    (cand),
        .is_ctrl (is_ctrl),
        .cd      (tok_cd),
        .d       (data)
    );

    assign phase_inc = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
    assign win_end   = (win_cnt == CNT_W'(SEARCH_WINDOW - 1));
    assign lock_hit  = is_ctrl && (run_cnt == RUN_W'(LOCK_RUN - 1));
    assign locked    = (state == ST_LOCKED);

    // Lock state after this edge; outputs follow it so they drop on the same cycle as locked
    assign locked_nxt = (state == ST_LOCKED) ? (is_ctrl || !win_end) : lock_hit;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            prev_word <= '0;
            state     <= ST_SEARCH;
            phase     <= 4'd0;
            win_cnt   <= '0;
            run_cnt   <= '0;
            sym_err   <= 1'b0;
        end else begin
            prev_word <= raw_word;
            sym_err   <= 1'b0;
            if (state == ST_SEARCH) begin
                if (lock_hit) begin
                    state   <= ST_LOCKED;
                    win_cnt <= '0;
                    run_cnt <= '0;
                end else if (win_end) begin
                    phase   <= phase_inc;
                    win_cnt <= '0;
                    run_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    run_cnt <= is_ctrl ? run_cnt + 1'b1 : '0;
                end
            end else begin
                // win_cnt doubles as the token-starvation timer here
                if (is_ctrl) begin
                    win_cnt <= '0;
                end else if (win_end) begin
                    state   <= ST_SEARCH;
                    sym_err <= 1'b1;
                    phase   <= phase_inc;
                    win_cnt <= '0;
                    run_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            vd  <= 8'h00;
            cd  <= 2'b00;
            vde <= 1'b0;
        end else if (!locked_nxt) begin
            vd  <= 8'h00;
            cd  <= 2'b00;
            vde <= 1'b0;
        end else if (is_ctrl) begin
            cd  <= tok_cd;
            vde <= 1'b0;
        end else begin
            vd  <= data;
            vde <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed + randomized bench for tmds_channel_decoder against a cycle-level reference model.
module tb_tmds_channel_decoder;

    localparam int LOCK_RUN = 16;
    localparam int SW       = 64;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b0;
    logic [9:0] raw_word  = 10'h000;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde, locked, sym_err;
    logic [3:0] phase;

    int checks = 0;
    int errors = 0;

    tmds_channel_decoder #(.LOCK_RUN(LOCK_RUN), .SEARCH_WINDOW(SW), .CNT_W(11)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .raw_word  (raw_word),
        .vd        (vd),
        .cd        (cd),
        .vde       (vde),
        .locked    (locked),
        .phase     (phase),
        .sym_err   (sym_err)
    );

    always #20 clk_pixel = ~clk_pixel;

    // Reference model state
    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] m_prev;
    int         m_phase, m_win, m_run, m_starve;
    bit         m_locked, m_vde, m_err;
    logic [7:0] m_vd;
    logic [1:0] m_cd;

    // Invert the transmitter's encoding by trying every byte through the encoder
    function automatic logic [7:0] ref_decode(input logic [9:0] c);
        logic [7:0] dv, qm, enc;
        for (int v = 0; v < 256; v++) begin
            dv = v[7:0];
            qm[0] = dv[0];
            for (int i = 1; i < 8; i++)
                qm[i] = c[8] ? (qm[i-1] ^ dv[i]) : ~(qm[i-1] ^ dv[i]);
            enc = c[9] ? ~qm : qm;
            if (enc == c[7:0]) return dv;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_phase = 0; m_win = 0; m_run = 0; m_starve = 0;
        m_locked = 0; m_vde = 0; m_err = 0; m_vd = 0; m_cd = 0;
    endtask

    task automatic model_step(input logic [9:0] w);
        logic [19:0] cat;
        logic [9:0]  c;
        int          tok;
        cat = {w, m_prev} >> m_phase;
        c   = cat[9:0];
        tok = -1;
        for (int k = 0; k < 4; k++) if (c == toks[k]) tok = k;
        m_err = 0;
        if (!m_locked) begin
            m_win++;
            m_run = (tok >= 0) ? m_run + 1 : 0;
            if (m_run == LOCK_RUN) begin
                m_locked = 1; m_run = 0; m_starve = 0; m_win = 0;
            end else if (m_win == SW) begin
                m_phase = (m_phase + 1) % 10; m_win = 0; m_run = 0;
            end
        end else begin
            m_starve = (tok >= 0) ? 0 : m_starve + 1;
            if (m_starve == SW) begin
                m_locked = 0; m_err = 1; m_phase = (m_phase + 1) % 10;
                m_starve = 0; m_win = 0; m_run = 0;
            end
        end
        if (!m_locked) begin
            m_vd = 0; m_cd = 0; m_vde = 0;
        end else if (tok >= 0) begin
            m_cd = 2'(tok); m_vde = 0;
        end else begin
            m_vd = ref_decode(c); m_vde = 1;
        end
        m_prev = w;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("vd", 32'(vd), 32'(m_vd));
        chk("cd", 32'(cd), 32'(m_cd));
        chk("vde", 32'(vde), 32'(m_vde));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("sym_err", 32'(sym_err), 32'(m_err));
    endtask

    task automatic step(input logic [9:0] w);
        raw_word = w;
        model_step(w);
        @(posedge clk_pixel);
        #1;
        check_model();
    endtask

    function automatic logic [9:0] shift_word(input logic [9:0] cur, input logic [9:0] prv, input int dly);
        logic [19:0] c;
        c = {cur, prv} >> (10 - dly);
        return c[9:0];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        bit         is_tok;
        do begin
            w = 10'($urandom_range(0, 1023));
            is_tok = 0;
            for (int k = 0; k < 4; k++) if (w == toks[k]) is_tok = 1;
        end while (is_tok);
        return w;
    endfunction

    initial begin
        int         n, start;
        bit         seen;
        logic [9:0] orig, oprev, w;
        int         dly, left, tk;
        bit         in_tok;

        // Reset values
        model_reset();
        repeat (3) @(posedge clk_pixel);
        #1;
        check_model();
        reset_n = 1'b1;

        // Aligned CTRL_00 run locks after the 16th token reaches the candidate window
        for (int i = 1; i <= 20; i++) begin
            step(10'h354);
            if (i == 16) chk("t1_not_yet", 32'(locked), 32'd0);
            if (i == 17) chk("t1_locked", 32'(locked), 32'd1);
        end
        chk("t1_cd", 32'(cd), 32'd0);
        chk("t1_vde", 32'(vde), 32'd0);
        chk("t1_phase", 32'(phase), 32'd0);

        // Data decode with two-cycle latency at phase 0
        step(10'h100); chk("t2_vde0", 32'(vde), 32'd0);
        step(10'h200); chk("t2_vd00", 32'({vde, vd}), 32'h100);
        step(10'h0AB); chk("t2_vdff", 32'({vde, vd}), 32'h1FF);
        step(10'h354); chk("t2_cd01", 32'({vde, cd}), 32'h001);

        // Token starvation while locked
        n = 0;
        for (int i = 1; i <= 80; i++) begin
            step(10'h100);
            n = i;
            if (sym_err) break;
        end
        chk("t4_timeout_step", 32'(n), 32'd65);
        chk("t4_sym_err", 32'(sym_err), 32'd1);
        chk("t4_locked", 32'(locked), 32'd0);
        chk("t4_vde", 32'(vde), 32'd0);
        chk("t4_phase", 32'(phase), 32'd1);
        step(10'h100);
        chk("t4_pulse_end", 32'(sym_err), 32'd0);

        // Phase 9 wraps to 0 in SEARCH without an error pulse
        for (int i = 0; i < 9 * SW + 10 && phase != 4'd9; i++) step(10'h100);
        chk("t5_at9", 32'(phase), 32'd9);
        n = 0; seen = 0;
        for (int i = 1; i <= 70; i++) begin
            step(10'h100);
            if (sym_err) seen = 1;
            n = i;
            if (phase == 4'd0) break;
        end
        chk("t5_wrap_steps", 32'(n), 32'd64);
        chk("t5_no_err", 32'(seen), 32'd0);

        // Stream delayed by 3 bits: hunt must settle at phase 3
        oprev = 10'h100; n = 0;
        for (int i = 0; i < 400; i++) begin
            orig = ((i % 56) < 16) ? 10'h354 : 10'h100;
            step(shift_word(orig, oprev, 3));
            oprev = orig;
            n = i + 1;
            if (locked) break;
        end
        chk("t3_locked", 32'(locked), 32'd1);
        chk("t3_phase", 32'(phase), 32'd3);
        chk("t3_hunt_len", 32'(n > 3 * SW), 32'd1);
        start = n;
        for (int i = start; i < start + 80; i++) begin
            orig = ((i % 56) < 16) ? 10'h354 : 10'h100;
            step(shift_word(orig, oprev, 3));
            oprev = orig;
            if (vde) break;
        end
        chk("t3_vde", 32'(vde), 32'd1);
        chk("t3_vd", 32'(vd), 32'd0);

        // Asynchronous reset mid-stream while locked at phase 3
        chk("t6_pre", 32'({locked, phase}), 32'h13);
        reset_n = 1'b0;
        #1;
        chk("t6_vd", 32'(vd), 32'd0);
        chk("t6_cd_vde", 32'({cd, vde}), 32'd0);
        chk("t6_locked", 32'(locked), 32'd0);
        chk("t6_phase", 32'(phase), 32'd0);
        chk("t6_sym_err", 32'(sym_err), 32'd0);
        reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 17; i++) begin
            step(10'h354);
            if (i == 16) chk("t6_relock_wait", 32'(locked), 32'd0);
        end
        chk("t6_relocked", 32'(locked), 32'd1);

        // Randomized: random bit offset, bursts of random tokens and random data
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_reset();
        dly = $urandom_range(0, 9);
        oprev = 10'h000; left = 0; in_tok = 0; tk = 0;
        for (int i = 0; i < 2500; i++) begin
            if (left == 0) begin
                in_tok = !in_tok;
                left = in_tok ? $urandom_range(12, 30) : $urandom_range(10, 90);
                tk = $urandom_range(0, 3);
            end
            left--;
            w = in_tok ? toks[tk] : rand_data();
            step(shift_word(w, oprev, dly));
            oprev = w;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
